// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: FSM states, ALU operation codes,
// flag bit positions and opcode-class helpers.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OPC,
      MODRM,
      IMM_LO,
      IMM_HI,
      EXEC,
      WB
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_OR,
      ALU_ADC,
      ALU_SBB,
      ALU_AND,
      ALU_SUB,
      ALU_XOR,
      ALU_CMP
   } alumode_t;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_P = 2;
   localparam int unsigned FLAG_A = 4;
   localparam int unsigned FLAG_Z = 6;
   localparam int unsigned FLAG_S = 7;
   localparam int unsigned FLAG_O = 11;

   // 00mmmfff with form fff in 0..5: the eight classic two-operand ALU ops
   function automatic logic is_alu_opc(input logic [7:0] op);
      return (op[7:6] == 2'b00) && (op[2:0] < 3'd6);
   endfunction

   // 80..83: immediate group, operation taken from the ModRM reg field
   function automatic logic is_grp1_opc(input logic [7:0] op);
      return op[7:2] == 6'b100000;
   endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// alu: combinational 8/16-bit ALU; rewrites C,P,A,Z,S,O and passes the
// remaining flag bits through unchanged.
module alu
   import alu_seq_pkg::*;
(
   input  alumode_t    mode,
   input  logic        size,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [11:0] flags_in,
   output logic [15:0] result,
   output logic [11:0] flags_out
);

   logic [15:0] am;
   logic [15:0] bm;
   logic [16:0] sum;
   logic [15:0] ov_vec;
   logic        arith;
   logic        sub;

   always_comb begin
      am    = size ? a : {8'h00, a[7:0]};
      bm    = size ? b : {8'h00, b[7:0]};
      sum   = '0;
      arith = 1'b1;
      sub   = 1'b0;
      // byte operands are zero-extended, so bit 8 carries the byte carry/borrow
      case (mode)
         ALU_ADD: sum = {1'b0, am} + {1'b0, bm};
         ALU_ADC: sum = {1'b0, am} + {1'b0, bm} + {16'h0000, flags_in[FLAG_C]};
         ALU_SBB: begin
            sum = {1'b0, am} - {1'b0, bm} - {16'h0000, flags_in[FLAG_C]};
            sub = 1'b1;
         end
         ALU_SUB, ALU_CMP: begin
            sum = {1'b0, am} - {1'b0, bm};
            sub = 1'b1;
         end
         ALU_OR: begin
            sum   = {1'b0, am | bm};
            arith = 1'b0;
         end
         ALU_AND: begin
            sum   = {1'b0, am & bm};
            arith = 1'b0;
         end
         ALU_XOR: begin
            sum   = {1'b0, am ^ bm};
            arith = 1'b0;
         end
         default: sum = '0;
      endcase

      result = size ? sum[15:0] : {8'h00, sum[7:0]};
      ov_vec = sub ? ((am ^ bm) & (am ^ result)) : (~(am ^ bm) & (am ^ result));

      flags_out         = flags_in;
      flags_out[FLAG_C] = arith & (size ? sum[16] : sum[8]);
      flags_out[FLAG_P] = ~^result[7:0];
      flags_out[FLAG_A] = arith & (am[4] ^ bm[4] ^ result[4]);
      flags_out[FLAG_Z] = size ? (result == 16'h0000) : (result[7:0] == 8'h00);
      flags_out[FLAG_S] = size ? result[15] : result[7];
      flags_out[FLAG_O] = arith & (size ? ov_vec[15] : ov_vec[7]);
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: byte-stream sequencer for x86-style two-operand ALU instructions.
// Define ALU_SEQ_GRP1_EN to support the 80..83 immediate group.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter logic [11:0] RESET_FLAGS = 12'h002
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        wb_valid,
   output logic [2:0]  wb_reg,
   output logic        wb_size,
   output logic [15:0] wb_data,
   output logic [11:0] flags_q,
   output logic        done,
   output logic        err,
   input  logic [2:0]  dbg_sel,
   output logic [15:0] dbg_data
);

   state_t      state;
   state_t      next_state;
   logic [15:0] regs [8];
   logic [11:0] flags_r;

   alumode_t    op_mode;
   logic        op_size;
   logic        op_dir;
   logic        op_imm;
   logic        op_sext;
   logic        op_grp;
   logic [2:0]  op_dst;
   logic [2:0]  op_src;
   logic [15:0] op_imm_val;

   logic [15:0] res_q;
   logic [11:0] rflags_q;
   logic        err_q;

   logic        accept;
   logic        fault;
   logic        dec_alu;
   logic        dec_grp;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [15:0] alu_res;
   logic [11:0] alu_flags;

   assign accept  = in_valid & in_ready;
   assign dec_alu = is_alu_opc(in_data);
`ifdef ALU_SEQ_GRP1_EN
   assign dec_grp = is_grp1_opc(in_data);
`else
   assign dec_grp = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= OPC;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      fault      = 1'b0;
      case (state)
         OPC: if (accept) begin
            if (dec_grp)      next_state = MODRM;
            else if (dec_alu) next_state = in_data[2] ? IMM_LO : MODRM;
            else              fault      = 1'b1;
         end
         MODRM: if (accept) begin
            if (in_data[7:6] != 2'b11) begin
               next_state = OPC;
               fault      = 1'b1;
            end else begin
               next_state = op_grp ? IMM_LO : EXEC;
            end
         end
         IMM_LO:  if (accept) next_state = (op_size & ~op_sext) ? IMM_HI : EXEC;
         IMM_HI:  if (accept) next_state = EXEC;
         EXEC:    next_state = WB;
         WB:      next_state = OPC;
         default: next_state = OPC;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      wb_valid = 1'b0;
      done     = 1'b0;
      case (state)
         OPC, MODRM, IMM_LO, IMM_HI: in_ready = 1'b1;
         WB: begin
            done     = 1'b1;
            wb_valid = (op_mode != ALU_CMP);
         end
         default: ;
      endcase
   end

   function automatic logic [15:0] pick(input logic [15:0] w, input logic hi, input logic sz);
      if (sz)      return w;
      else if (hi) return {8'h00, w[15:8]};
      else         return {8'h00, w[7:0]};
   endfunction

   // byte encodings 4..7 select the high half of registers 0..3
   assign opa = pick(regs[op_size ? op_dst : {1'b0, op_dst[1:0]}], op_dst[2], op_size);
   assign opb = op_imm ? op_imm_val
                       : pick(regs[op_size ? op_src : {1'b0, op_src[1:0]}], op_src[2], op_size);

   alu u_alu (
      .mode      (op_mode),
      .size      (op_size),
      .a         (opa),
      .b         (opb),
      .flags_in  (flags_r),
      .result    (alu_res),
      .flags_out (alu_flags)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
         flags_r    <= RESET_FLAGS;
         op_mode    <= ALU_ADD;
         op_size    <= 1'b0;
         op_dir     <= 1'b0;
         op_imm     <= 1'b0;
         op_sext    <= 1'b0;
         op_grp     <= 1'b0;
         op_dst     <= '0;
         op_src     <= '0;
         op_imm_val <= '0;
         res_q      <= '0;
         rflags_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= fault;
         case (state)
            OPC: if (accept) begin
               op_grp  <= dec_grp;
               op_size <= in_data[0];
               op_dir  <= in_data[1];
               op_sext <= dec_grp & (in_data[1:0] == 2'b11);
               op_imm  <= dec_grp | in_data[2];
               op_mode <= alumode_t'(in_data[5:3]);
               op_dst  <= '0;
            end
            MODRM: if (accept) begin
               if (op_grp) begin
                  op_mode <= alumode_t'(in_data[5:3]);
                  op_dst  <= in_data[2:0];
               end else if (op_dir) begin
                  op_dst <= in_data[5:3];
                  op_src <= in_data[2:0];
               end else begin
                  op_dst <= in_data[2:0];
                  op_src <= in_data[5:3];
               end
            end
            IMM_LO: if (accept) op_imm_val <= {op_sext ? {8{in_data[7]}} : 8'h00, in_data};
            IMM_HI: if (accept) op_imm_val[15:8] <= in_data;
            EXEC: begin
               res_q    <= alu_res;
               rflags_q <= alu_flags;
            end
            WB: begin
               flags_r <= rflags_q;
               if (op_mode != ALU_CMP) begin
                  if (op_size)        regs[op_dst] <= res_q;
                  else if (op_dst[2]) regs[{1'b0, op_dst[1:0]}][15:8] <= res_q[7:0];
                  else                regs[{1'b0, op_dst[1:0]}][7:0]  <= res_q[7:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign wb_reg   = op_dst;
   assign wb_size  = op_size;
   assign wb_data  = res_q;
   assign flags_q  = flags_r;
   assign err      = err_q;
   assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with an arithmetic reference model;
// honours ALU_SEQ_GRP1_EN the same way as the design.
module tb_alu_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wb_valid;
   logic [2:0]  wb_reg;
   logic        wb_size;
   logic [15:0] wb_data;
   logic [11:0] flags_q;
   logic        done;
   logic        err;
   logic [2:0]  dbg_sel;
   logic [15:0] dbg_data;

   alu_seq #(.RESET_FLAGS(12'h002)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wb_valid (wb_valid),
      .wb_reg   (wb_reg),
      .wb_size  (wb_size),
      .wb_data  (wb_data),
      .flags_q  (flags_q),
      .done     (done),
      .err      (err),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   always #5 clock = ~clock;

`ifdef ALU_SEQ_GRP1_EN
   localparam bit GRP_EN = 1'b1;
`else
   localparam bit GRP_EN = 1'b0;
`endif

   // kind: 0 = write-back, 1 = done without write-back (CMP), 2 = err pulse
   typedef struct {
      int          kind;
      logic [2:0]  rg;
      logic        sz;
      logic [15:0] data;
      logic [11:0] fl;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          gaps = 1'b0;
   logic [15:0] m_regs [8];
   logic [11:0] m_flags;
   bit          fl_pend = 1'b0;
   logic [11:0] fl_exp;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_flags = 12'h002;
   endtask

   function automatic int rd(input int idx, input bit w);
      if (w)            return int'(m_regs[idx]);
      else if (idx < 4) return int'(m_regs[idx][7:0]);
      else              return int'(m_regs[idx-4][15:8]);
   endfunction

   task automatic wr(input int idx, input bit w, input int v);
      if (w)            m_regs[idx] = v[15:0];
      else if (idx < 4) m_regs[idx][7:0] = v[7:0];
      else              m_regs[idx-4][15:8] = v[7:0];
   endtask

   // Plain-integer reference: carry from unsigned range, overflow from signed range.
   task automatic model_alu(input int mode, input bit w, input int a_in, input int b_in,
                            input logic [11:0] fi, output logic [11:0] fo, output int r);
      int mask, half, xa, xb, full, sa, sbv, sr;
      bit c, arith, cin;
      mask  = w ? 'hFFFF : 'hFF;
      half  = w ? 'h8000 : 'h80;
      xa    = a_in & mask;
      xb    = b_in & mask;
      cin   = fi[0];
      sa    = (xa >= half) ? xa - 2*half : xa;
      sbv   = (xb >= half) ? xb - 2*half : xb;
      arith = 1'b1;
      c     = 1'b0;
      sr    = 0;
      full  = 0;
      case (mode)
         0: begin full = xa + xb;       sr = sa + sbv;       c = full > mask; end
         2: begin full = xa + xb + int'(cin); sr = sa + sbv + int'(cin); c = full > mask; end
         3: begin full = xa - xb - int'(cin); sr = sa - sbv - int'(cin); c = xa < xb + int'(cin); end
         5, 7: begin full = xa - xb;    sr = sa - sbv;       c = xa < xb; end
         1: begin full = xa | xb; arith = 1'b0; end
         4: begin full = xa & xb; arith = 1'b0; end
         default: begin full = xa ^ xb; arith = 1'b0; end
      endcase
      r      = full & mask;
      fo     = fi;
      fo[0]  = c;
      fo[2]  = ($countones(r & 'hFF) % 2) == 0;
      fo[4]  = arith ? 1'(((xa ^ xb ^ r) >> 4) & 1) : 1'b0;
      fo[6]  = (r == 0);
      fo[7]  = (r >= half);
      fo[11] = arith && ((sr < -half) || (sr >= half));
   endtask

   // Decodes the byte list, returns how many bytes the block consumes and
   // the expected response, and advances the model state.
   task automatic predict(input logic [7:0] b[4], output int n, output exp_t e);
      logic [7:0]  op;
      logic [11:0] f;
      int          mode, dst, src, a, bv, r;
      bit          w, grp, immf, sx, d;
      op     = b[0];
      e.kind = 2; e.rg = '0; e.sz = 1'b0; e.data = '0; e.fl = m_flags; e.cyc = 0;
      n      = 1;
      grp    = GRP_EN && (op >= 8'h80) && (op <= 8'h83);
      if (!grp && !((op[7:6] == 2'b00) && (op[2:0] < 3'd6))) return;
      if (grp || (op[2:0] < 3'd4)) begin
         n = 2;
         if (b[1][7:6] != 2'b11) return;
      end
      w   = op[0];
      sx  = 1'b0;
      src = 0;
      if (grp) begin
         mode = int'(b[1][5:3]);
         dst  = int'(b[1][2:0]);
         immf = 1'b1;
         sx   = (op == 8'h83);
      end else begin
         mode = int'(op[5:3]);
         if (op[2]) begin
            dst  = 0;
            immf = 1'b1;
         end else begin
            immf = 1'b0;
            d    = op[1];
            dst  = d ? int'(b[1][5:3]) : int'(b[1][2:0]);
            src  = d ? int'(b[1][2:0]) : int'(b[1][5:3]);
         end
      end
      if (immf) begin
         if (w && !sx) begin
            bv = int'({b[n+1], b[n]});
            n  = n + 2;
         end else begin
            bv = (sx && b[n][7]) ? ('hFF00 | int'(b[n])) : int'(b[n]);
            n  = n + 1;
         end
      end else begin
         bv = rd(src, w);
      end
      a = rd(dst, w);
      model_alu(mode, w, a, bv, m_flags, f, r);
      m_flags = f;
      if (mode == 7) e.kind = 1;
      else begin
         e.kind = 0;
         wr(dst, w, r);
      end
      e.rg   = 3'(dst);
      e.sz   = w;
      e.data = 16'(r);
      e.fl   = f;
   endtask

   task automatic send_byte(input logic [7:0] b, output int acc);
      int n;
      n = 0;
      if (gaps && ($urandom_range(0, 5) == 0)) begin
         in_data = 8'($urandom);
         repeat ($urandom_range(1, 3)) @(negedge clock);
      end
      @(negedge clock);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && (n < 40)) begin
         @(negedge clock);
         n++;
      end
      acc = cyc;
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] bb[4];
      int         n, acc;
      exp_t       e;
      bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
      acc   = 0;
      predict(bb, n, e);
      for (int i = 0; i < n; i++) send_byte(bb[i], acc);
      e.cyc = acc + ((e.kind == 2) ? 1 : 2);
      sbq.push_back(e);
   endtask

   task automatic wait_idle();
      repeat (4) @(negedge clock);
   endtask

   task automatic check_reg(input string name, input int idx, input logic [15:0] expv);
      @(negedge clock);
      dbg_sel = 3'(idx);
      #1 check(name, 32'(dbg_data), 32'(expv));
   endtask

   task automatic check_regs();
      for (int i = 0; i < 8; i++) check_reg($sformatf("dbg_reg%0d", i), i, m_regs[i]);
   endtask

   // monitor: every strobe from the block consumes one scoreboard entry
   initial forever begin
      exp_t e;
      int   k;
      @(negedge clock);
      if (fl_pend) begin
         check("flags_after_wb", 32'(flags_q), 32'(fl_exp));
         fl_pend = 1'b0;
      end
      if (!reset && (wb_valid || done || err)) begin
         k = err ? ((wb_valid || done) ? 3 : 2) : (wb_valid ? (done ? 0 : 3) : 1);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", k, cyc);
         end else begin
            e = sbq.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_cycle", 32'(cyc), 32'(e.cyc));
            if (e.kind == 0) begin
               check("wb_reg", 32'(wb_reg), 32'(e.rg));
               check("wb_size", 32'(wb_size), 32'(e.sz));
               check("wb_data", 32'(wb_data), 32'(e.data));
            end
            if (e.kind != 2) begin
               fl_pend = 1'b1;
               fl_exp  = e.fl;
            end
         end
      end
   end

   initial begin
      int         acc;
      int         r;
      logic [7:0] op;
      logic [7:0] m;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      dbg_sel  = '0;
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("in_ready_after_reset", 32'(in_ready), 32'd1);
      check("flags_after_reset", 32'(flags_q), 32'h002);
      for (int i = 0; i < 8; i++) check_reg($sformatf("reset_reg%0d", i), i, 16'h0000);

      run_instr(8'h05, 8'h34, 8'h12, 8'h00);
      wait_idle();
      check_reg("add_ax_imm_ax", 0, 16'h1234);
      check("add_ax_imm_flags", 32'(flags_q), 32'h002);

      run_instr(8'h3C, 8'h34, 8'h00, 8'h00);
      wait_idle();
      check_reg("cmp_al_ax", 0, 16'h1234);
      check("cmp_al_flags", 32'(flags_q), 32'h046);

      run_instr(8'h2C, 8'h35, 8'h00, 8'h00);
      wait_idle();
      check_reg("sub_al_ax", 0, 16'h12FF);
      check("sub_al_flags", 32'(flags_q), 32'h097);

      run_instr(8'h00, 8'hC4, 8'h00, 8'h00);
      wait_idle();
      check_reg("add_ah_al_ax", 0, 16'h11FF);
      check("add_ah_al_carry", 32'(flags_q[0]), 32'd1);

      run_instr(8'h83, 8'hC0, 8'hFF, 8'h00);
      wait_idle();
      check_reg("grp83_ax", 0, GRP_EN ? 16'h11FE : 16'h11FF);
      check("grp83_carry", 32'(flags_q[0]), 32'd1);

      run_instr(8'h00, 8'h06, 8'h00, 8'h00);
      wait_idle();
      check_regs();

      send_byte(8'h05, acc);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      run_instr(8'h34, 8'h0F, 8'h00, 8'h00);
      wait_idle();
      check_reg("after_mid_reset_ax", 0, 16'h000F);

      gaps = 1'b1;
      for (int t = 0; t < 400; t++) begin
         r = int'($urandom_range(0, 99));
         m = {2'b11, 6'($urandom)};
         if (r < 55)      op = {2'b00, 3'($urandom), 3'($urandom_range(0, 5))};
         else if (r < 75) op = {6'b100000, 2'($urandom)};
         else if (r < 85) op = 8'($urandom);
         else begin
            op      = {2'b00, 3'($urandom), 3'($urandom_range(0, 3))};
            m[7:6]  = 2'($urandom_range(0, 2));
         end
         run_instr(op, m, 8'($urandom), 8'($urandom));
      end
      wait_idle();
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      check("final_flags", 32'(flags_q), 32'(m_flags));
      check_regs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
